// File: rtl/bus_seq_pkg.sv
// Shared types and widths for the bus tag sequencer and its tag table.
package bus_seq_pkg;

  localparam int NUM_COL_DEF = 8;
  localparam int ID_W        = $clog2(NUM_COL_DEF) + 1;
  localparam logic [ID_W-1:0] NO_ID = '1;

  typedef enum logic [2:0] {
    IDLE,
    KFLUSH,
    KWAIT,
    TFLUSH,
    TWAIT,
    STREAM,
    DONE
  } seq_state_e;

  // One extra bit above the column index leaves room for an ID no column owns.
  function automatic int id_width(input int num_col);
    return $clog2(num_col) + 1;
  endfunction

endpackage

// File: rtl/tag_table.sv
// Per-column TAG register file: one write port, one combinational read port,
// cleared to the no-column value on reset.
module tag_table
  import bus_seq_pkg::*;
#(
  parameter int DEPTH = NUM_COL_DEF,
  parameter int W = ID_W,
  parameter logic [W-1:0] CLEAR_VAL = W'(NO_ID)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= CLEAR_VAL;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_tag_sequencer.sv
// Job controller for one X-bus: kernel-size flush, per-column tag flush, then
// a stream of ID-stamped ifmap/filter/psum beats, closing with a done pulse.
module bus_tag_sequencer
  import bus_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = NUM_COL_DEF,
  parameter int LEN_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_COL)-1:0] cfg_addr,
  input  logic [$clog2(NUM_COL):0]   cfg_tag,
  input  logic [7:0]                 cfg_kernel_size,
  input  logic [LEN_W-1:0]           cfg_len,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic                       src_valid,
  output logic                       src_ready,
  input  logic [$clog2(NUM_COL):0]   src_id,
  input  logic [DATA_WIDTH-1:0]      src_ifmap,
  input  logic [DATA_WIDTH-1:0]      src_fltr,
  input  logic [2*DATA_WIDTH-1:0]    src_psum,
  output logic [$clog2(NUM_COL):0]   ID,
  output logic [$clog2(NUM_COL):0]   TAG,
  output logic                       flush_tag,
  input  logic                       tag_busy,
  output logic                       flush_kernel,
  input  logic                       kernel_busy,
  output logic [7:0]                 kernel_size,
  output logic                       bus_valid,
  output logic [DATA_WIDTH-1:0]      ifmap_data_B2M,
  output logic [DATA_WIDTH-1:0]      fltr_data_B2M,
  output logic [2*DATA_WIDTH-1:0]    psum_data_B2M
);

  localparam int CW = $clog2(NUM_COL);
  localparam int TW = id_width(NUM_COL);
  localparam logic [TW-1:0] NO_TAG = '1;

  seq_state_e       state;
  logic [CW-1:0]    col;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt;
  logic [TW-1:0]    rd_tag;
  logic             last_col;

  assign last_col  = (col == CW'(NUM_COL - 1));
  assign src_ready = (state == STREAM);

  tag_table #(
    .DEPTH    (NUM_COL),
    .W        (TW),
    .CLEAR_VAL(NO_TAG)
  ) u_tag_table (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (cfg_we && (state == IDLE)),
    .waddr(cfg_addr),
    .wdata(cfg_tag),
    .raddr(col),
    .rdata(rd_tag)
  );

  // Every output is registered, so each pulse shows up the cycle after the
  // state that requests it; the wait states ignore the busy inputs while
  // their own flush is still visible because the multicasters lag by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      col            <= '0;
      len_r          <= '0;
      cnt            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ID             <= NO_TAG;
      TAG            <= NO_TAG;
      flush_tag      <= 1'b0;
      flush_kernel   <= 1'b0;
      kernel_size    <= '0;
      bus_valid      <= 1'b0;
      ifmap_data_B2M <= '0;
      fltr_data_B2M  <= '0;
      psum_data_B2M  <= '0;
    end else begin
      flush_kernel <= 1'b0;
      flush_tag    <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            kernel_size <= cfg_kernel_size;
            len_r       <= cfg_len;
            busy        <= 1'b1;
            state       <= KFLUSH;
          end
        end
        KFLUSH: begin
          flush_kernel <= 1'b1;
          state        <= KWAIT;
        end
        KWAIT: begin
          if (!flush_kernel && !kernel_busy) begin
            col   <= '0;
            state <= TFLUSH;
          end
        end
        TFLUSH: begin
          ID        <= {1'b0, col};
          TAG       <= rd_tag;
          flush_tag <= 1'b1;
          state     <= TWAIT;
        end
        TWAIT: begin
          if (!flush_tag && !tag_busy) begin
            if (last_col) begin
              ID    <= NO_TAG;
              TAG   <= NO_TAG;
              cnt   <= '0;
              state <= (len_r == '0) ? DONE : STREAM;
            end else begin
              col   <= col + CW'(1);
              state <= TFLUSH;
            end
          end
        end
        STREAM: begin
          if (src_valid) begin
            bus_valid      <= 1'b1;
            ID             <= src_id;
            ifmap_data_B2M <= src_ifmap;
            fltr_data_B2M  <= src_fltr;
            psum_data_B2M  <= src_psum;
            cnt            <= cnt + LEN_W'(1);
            if ((cnt + LEN_W'(1)) == len_r) begin
              state <= DONE;
            end
          end else begin
            bus_valid <= 1'b0;
            ID        <= NO_TAG;
          end
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          bus_valid <= 1'b0;
          ID        <= NO_TAG;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_tag_sequencer.sv
// Randomized job-level bench for bus_tag_sequencer with responding multicaster
// busy models and an event-log reference comparison.
module tb_bus_tag_sequencer;
  import bus_seq_pkg::*;

  localparam int DW = 16;
  localparam int NC = 8;
  localparam int LW = 16;
  localparam int IW = ID_W;
  localparam int CW = $clog2(NC);
  localparam int BW = IW + 4 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [CW-1:0] cfg_addr = '0;
  logic [IW-1:0] cfg_tag = '0;
  logic [7:0]    cfg_kernel_size = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          start = 1'b0;
  logic          busy, done;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [IW-1:0] src_id = '0;
  logic [DW-1:0] src_ifmap = '0, src_fltr = '0;
  logic [2*DW-1:0] src_psum = '0;
  logic [IW-1:0] ID, TAG;
  logic          flush_tag, tag_busy, flush_kernel, kernel_busy;
  logic [7:0]    kernel_size;
  logic          bus_valid;
  logic [DW-1:0] ifmap_data_B2M, fltr_data_B2M;
  logic [2*DW-1:0] psum_data_B2M;

  bus_tag_sequencer #(.DATA_WIDTH(DW), .NUM_COL(NC), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_tag(cfg_tag),
    .cfg_kernel_size(cfg_kernel_size), .cfg_len(cfg_len), .start(start), .busy(busy),
    .done(done), .src_valid(src_valid), .src_ready(src_ready), .src_id(src_id),
    .src_ifmap(src_ifmap), .src_fltr(src_fltr), .src_psum(src_psum), .ID(ID), .TAG(TAG),
    .flush_tag(flush_tag), .tag_busy(tag_busy), .flush_kernel(flush_kernel),
    .kernel_busy(kernel_busy), .kernel_size(kernel_size), .bus_valid(bus_valid),
    .ifmap_data_B2M(ifmap_data_B2M), .fltr_data_B2M(fltr_data_B2M), .psum_data_B2M(psum_data_B2M)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Multicasters go busy the cycle after a flush and stay busy for a set time.
  int kb_cycles = 2, tb_cycles = 2, kb_left = 0, tb_left = 0;
  always @(posedge clk) begin
    if (flush_kernel) kb_left <= kb_cycles;
    else if (kb_left > 0) kb_left <= kb_left - 1;
    if (flush_tag) tb_left <= tb_cycles;
    else if (tb_left > 0) tb_left <= tb_left - 1;
  end
  assign kernel_busy = (kb_left != 0);
  assign tag_busy    = (tb_left != 0);

  // Event log of everything the DUT puts on the bus, sampled mid-cycle.
  int            cyc = 0;
  int            kflush_cyc[$];
  logic [7:0]    kflush_val[$];
  int            tflush_cyc[$];
  logic [IW-1:0] tflush_id[$];
  logic [IW-1:0] tflush_tag[$];
  int            hs_cyc[$];
  int            beat_cyc[$];
  logic [BW-1:0] beat_q[$];
  logic [IW:0]   trace_q[$];
  int            done_cnt = 0;
  int            viol = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (flush_kernel) begin kflush_cyc.push_back(cyc); kflush_val.push_back(kernel_size); end
      if (flush_tag) begin tflush_cyc.push_back(cyc); tflush_id.push_back(ID); tflush_tag.push_back(TAG); end
      if (src_valid && src_ready) hs_cyc.push_back(cyc);
      if (bus_valid) begin
        beat_cyc.push_back(cyc);
        beat_q.push_back({ID, ifmap_data_B2M, fltr_data_B2M, psum_data_B2M});
      end
      trace_q.push_back({bus_valid, ID});
      if (done) done_cnt++;
      if (done && busy) viol++;
      if (flush_tag && flush_kernel) viol++;
      if ((flush_tag || flush_kernel) && bus_valid) viol++;
      if (flush_tag && tag_busy) viol++;
      if (flush_kernel && kernel_busy) viol++;
    end
  end

  logic [IW-1:0] ref_table [NC];
  logic [BW-1:0] exp_beats[$];
  int hs_count, ready_cycles, extra_ready, timed_out;

  task automatic clear_log();
    kflush_cyc.delete(); kflush_val.delete(); tflush_cyc.delete(); tflush_id.delete();
    tflush_tag.delete(); hs_cyc.delete(); beat_cyc.delete(); beat_q.delete(); trace_q.delete();
    done_cnt = 0; viol = 0;
  endtask

  task automatic write_table();
    for (int i = 0; i < NC; i++) begin
      cfg_we = 1'b1; cfg_addr = CW'(i); cfg_tag = ref_table[i];
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;
  endtask

  // mode 0: random valid, 1: always valid, 2: valid 1,0,1,1,..., 3: random valid plus start/cfg_we noise
  task automatic applyStimulus(input int kern, input int len, input int mode);
    int guard, rc;
    clear_log();
    exp_beats.delete();
    hs_count = 0; ready_cycles = 0; extra_ready = 0; rc = 0; guard = 0;
    cfg_kernel_size = 8'(kern); cfg_len = LW'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cfg_kernel_size = 8'($urandom); cfg_len = LW'($urandom);
    while (done_cnt == 0 && guard < 3000) begin
      if (src_ready) begin
        case (mode)
          1: src_valid = 1'b1;
          2: src_valid = (rc != 1);
          default: src_valid = 1'($urandom_range(0, 1));
        endcase
        rc++;
      end else begin
        src_valid = 1'($urandom_range(0, 1));
      end
      src_id = IW'($urandom); src_ifmap = DW'($urandom); src_fltr = DW'($urandom); src_psum = $urandom;
      if (mode == 3 && src_ready) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = CW'($urandom); cfg_tag = IW'($urandom);
      end else begin
        start = 1'b0; cfg_we = 1'b0;
      end
      if (src_ready) begin
        ready_cycles++;
        if (hs_count >= len) extra_ready++;
      end
      if (src_valid && src_ready) begin
        hs_count++;
        exp_beats.push_back({src_id, src_ifmap, src_fltr, src_psum});
      end
      @(posedge clk); #1;
      guard++;
    end
    src_valid = 1'b0; start = 1'b0; cfg_we = 1'b0;
    timed_out = (done_cnt == 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (ID !== NO_ID) begin errors++; $display("[TB] FAIL reset_ID got %0d want %0d", ID, NO_ID); end
    checks++; if (TAG !== NO_ID) begin errors++; $display("[TB] FAIL reset_TAG got %0d want %0d", TAG, NO_ID); end
    checks++; if ({busy, done, flush_tag, flush_kernel, bus_valid, src_ready} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl got %b want 000000", {busy, done, flush_tag, flush_kernel, bus_valid, src_ready});
    end
    checks++; if (kernel_size !== 8'd0) begin errors++; $display("[TB] FAIL reset_kernel_size got %0d want 0", kernel_size); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int d;
    for (int i = 0; i < NC; i++) ref_table[i] = IW'((NC + 3 - i) % NC);
    write_table();
    kb_cycles = 2; tb_cycles = 2;
    applyStimulus(3, 4, 1);
    checks++; if (timed_out != 0) begin errors++; $display("[TB] FAIL basic_timeout got %0d want 0", timed_out); end
    checks++; if (kflush_val.size() != 1) begin errors++; $display("[TB] FAIL basic_kflush_count got %0d want 1", kflush_val.size()); end
    else begin
      checks++; if (kflush_val[0] !== 8'd3) begin errors++; $display("[TB] FAIL basic_kflush_size got %0d want 3", kflush_val[0]); end
    end
    checks++; if (kernel_size !== 8'd3) begin errors++; $display("[TB] FAIL basic_kernel_size got %0d want 3", kernel_size); end
    checks++; if (tflush_id.size() != NC) begin errors++; $display("[TB] FAIL basic_tflush_count got %0d want %0d", tflush_id.size(), NC); end
    else begin
      for (int i = 0; i < NC; i++) begin
        checks++; if (tflush_id[i] !== IW'(i)) begin errors++; $display("[TB] FAIL basic_tflush_id[%0d] got %0d want %0d", i, tflush_id[i], i); end
        checks++; if (tflush_tag[i] !== ref_table[i]) begin errors++; $display("[TB] FAIL basic_tflush_tag[%0d] got %0d want %0d", i, tflush_tag[i], ref_table[i]); end
        d = (i == 0) ? tflush_cyc[0] - ((kflush_cyc.size() > 0) ? kflush_cyc[0] : 0) : tflush_cyc[i] - tflush_cyc[i-1];
        checks++; if (d < tb_cycles + 2 || d > tb_cycles + 4) begin errors++; $display("[TB] FAIL basic_flush_spacing[%0d] got %0d want %0d..%0d", i, d, tb_cycles + 2, tb_cycles + 4); end
      end
    end
    checks++; if (beat_q.size() != 4) begin errors++; $display("[TB] FAIL basic_beat_count got %0d want 4", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < exp_beats.size(); i++) begin
      checks++; if (beat_q[i] !== exp_beats[i]) begin errors++; $display("[TB] FAIL basic_beat[%0d] got %h want %h", i, beat_q[i], exp_beats[i]); end
      checks++; if (i < hs_cyc.size() && beat_cyc[i] != hs_cyc[i] + 1) begin errors++; $display("[TB] FAIL basic_beat_latency[%0d] got %0d want %0d", i, beat_cyc[i] - hs_cyc[i], 1); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL basic_done_count got %0d want 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_after got %b want 0", busy); end
    checks++; if (extra_ready != 0) begin errors++; $display("[TB] FAIL basic_ready_after_last got %0d want 0", extra_ready); end
    checks++; if (viol != 0) begin errors++; $display("[TB] FAIL basic_protocol got %0d want 0", viol); end
  endtask

  task automatic test_len_zero();
    applyStimulus(5, 0, 1);
    checks++; if (timed_out != 0) begin errors++; $display("[TB] FAIL len0_timeout got %0d want 0", timed_out); end
    checks++; if (tflush_id.size() != NC) begin errors++; $display("[TB] FAIL len0_tflush_count got %0d want %0d", tflush_id.size(), NC); end
    checks++; if (ready_cycles != 0) begin errors++; $display("[TB] FAIL len0_src_ready got %0d want 0", ready_cycles); end
    checks++; if (beat_q.size() != 0) begin errors++; $display("[TB] FAIL len0_beats got %0d want 0", beat_q.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL len0_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_valid_gaps();
    int f;
    logic [IW:0] want [5];
    applyStimulus(2, 3, 2);
    checks++; if (beat_q.size() != 3) begin errors++; $display("[TB] FAIL gaps_beat_count got %0d want 3", beat_q.size()); end
    checks++; if (ready_cycles != 4) begin errors++; $display("[TB] FAIL gaps_ready_cycles got %0d want 4", ready_cycles); end
    checks++; if (extra_ready != 0) begin errors++; $display("[TB] FAIL gaps_ready_after_last got %0d want 0", extra_ready); end
    f = -1;
    for (int i = 0; i < trace_q.size(); i++) if (f < 0 && trace_q[i][IW]) f = i;
    if (exp_beats.size() >= 3) begin
      want[0] = {1'b1, exp_beats[0][BW-1 -: IW]};
      want[1] = {1'b0, NO_ID};
      want[2] = {1'b1, exp_beats[1][BW-1 -: IW]};
      want[3] = {1'b1, exp_beats[2][BW-1 -: IW]};
      want[4] = {1'b0, NO_ID};
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (f < 0 || f + k >= trace_q.size() || trace_q[f + k] !== want[k]) begin
          errors++; $display("[TB] FAIL gaps_trace[%0d] got %h want %h", k, (f >= 0 && f + k < trace_q.size()) ? trace_q[f + k] : '0, want[k]);
        end
      end
    end else begin
      checks++; errors++; $display("[TB] FAIL gaps_handshakes got %0d want 3", exp_beats.size());
    end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL gaps_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_busy_ignores_cfg();
    applyStimulus(6, 5, 3);
    repeat (6) @(posedge clk);
    #1;
    checks++; if (kflush_val.size() != 1) begin errors++; $display("[TB] FAIL noise_restart got %0d want 1", kflush_val.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL noise_busy got %b want 0", busy); end
    checks++; if (beat_q.size() != 5) begin errors++; $display("[TB] FAIL noise_beats got %0d want 5", beat_q.size()); end
    applyStimulus(1, 1, 1);
    checks++; if (tflush_tag.size() != NC) begin errors++; $display("[TB] FAIL noise_tflush_count got %0d want %0d", tflush_tag.size(), NC); end
    else for (int i = 0; i < NC; i++) begin
      checks++; if (tflush_tag[i] !== ref_table[i]) begin errors++; $display("[TB] FAIL noise_table[%0d] got %0d want %0d", i, tflush_tag[i], ref_table[i]); end
    end
  endtask

  task automatic test_kernel_hold();
    kb_cycles = 50;
    applyStimulus(7, 2, 1);
    kb_cycles = 2;
    checks++; if (timed_out != 0) begin errors++; $display("[TB] FAIL khold_timeout got %0d want 0", timed_out); end
    checks++;
    if (kflush_cyc.size() != 1 || tflush_cyc.size() == 0 || tflush_cyc[0] - kflush_cyc[0] < 52) begin
      errors++; $display("[TB] FAIL khold_first_tag_flush got %0d want >=52", (kflush_cyc.size() > 0 && tflush_cyc.size() > 0) ? tflush_cyc[0] - kflush_cyc[0] : -1);
    end
    checks++;
    if (beat_cyc.size() == 0 || tflush_cyc.size() == 0 || beat_cyc[0] <= tflush_cyc[tflush_cyc.size() - 1]) begin
      errors++; $display("[TB] FAIL khold_beat_order got %0d want %0d", beat_cyc.size(), 2);
    end
    checks++; if (viol != 0) begin errors++; $display("[TB] FAIL khold_protocol got %0d want 0", viol); end
  endtask

  task automatic test_reset_mid_job();
    int guard = 0;
    clear_log();
    cfg_kernel_size = 8'd9; cfg_len = LW'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (tflush_id.size() < 5 && guard < 500) begin @(negedge clk); guard++; end
    checks++; if (tflush_id.size() < 5) begin errors++; $display("[TB] FAIL midrst_reach_col4 got %0d want 5", tflush_id.size()); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ID !== NO_ID) begin errors++; $display("[TB] FAIL midrst_ID got %0d want %0d", ID, NO_ID); end
    checks++; if (TAG !== NO_ID) begin errors++; $display("[TB] FAIL midrst_TAG got %0d want %0d", TAG, NO_ID); end
    checks++; if ({busy, done, flush_tag, flush_kernel, bus_valid, src_ready} !== 6'b0) begin
      errors++; $display("[TB] FAIL midrst_ctrl got %b want 000000", {busy, done, flush_tag, flush_kernel, bus_valid, src_ready});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (done_cnt != 0) begin errors++; $display("[TB] FAIL midrst_done got %0d want 0", done_cnt); end
    for (int i = 0; i < NC; i++) ref_table[i] = NO_ID;
    applyStimulus(4, 2, 0);
    checks++; if (kflush_val.size() != 1) begin errors++; $display("[TB] FAIL midrst_replay_kflush got %0d want 1", kflush_val.size()); end
    checks++; if (tflush_tag.size() != NC) begin errors++; $display("[TB] FAIL midrst_tflush_count got %0d want %0d", tflush_tag.size(), NC); end
    else for (int i = 0; i < NC; i++) begin
      checks++; if (tflush_tag[i] !== ref_table[i]) begin errors++; $display("[TB] FAIL midrst_table[%0d] got %0d want %0d", i, tflush_tag[i], ref_table[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL midrst_replay_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_random_jobs();
    int len, kern;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < NC; i++) ref_table[i] = IW'($urandom);
      write_table();
      kb_cycles = $urandom_range(1, 4); tb_cycles = $urandom_range(1, 4);
      len = $urandom_range(1, 6); kern = $urandom_range(0, 255);
      applyStimulus(kern, len, 0);
      checks++; if (beat_q.size() != len) begin errors++; $display("[TB] FAIL rand%0d_beat_count got %0d want %0d", j, beat_q.size(), len); end
      for (int i = 0; i < beat_q.size() && i < exp_beats.size(); i++) begin
        checks++; if (beat_q[i] !== exp_beats[i]) begin errors++; $display("[TB] FAIL rand%0d_beat[%0d] got %h want %h", j, i, beat_q[i], exp_beats[i]); end
      end
      for (int i = 0; i < tflush_tag.size() && i < NC; i++) begin
        checks++; if (tflush_tag[i] !== ref_table[i]) begin errors++; $display("[TB] FAIL rand%0d_tag[%0d] got %0d want %0d", j, i, tflush_tag[i], ref_table[i]); end
      end
      checks++; if (kernel_size !== 8'(kern)) begin errors++; $display("[TB] FAIL rand%0d_kernel got %0d want %0d", j, kernel_size, kern); end
      checks++; if (done_cnt != 1 || viol != 0) begin errors++; $display("[TB] FAIL rand%0d_done_protocol got %0d/%0d want 1/0", j, done_cnt, viol); end
    end
    kb_cycles = 2; tb_cycles = 2;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_valid_gaps();
    test_busy_ignores_cfg();
    test_kernel_hold();
    test_reset_mid_job();
    test_random_jobs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_tag_sequencer.md
Name: bus_tag_sequencer

Overview:
- Controller sitting between the global buffer and one X-bus of multicasters.
- Runs a job as follows:
  - broadcasts the kernel size with a flush_kernel handshake;
  - programs each column multicaster's TAG with a flush_tag handshake per column;
  - streams ifmap/filter/psum beats onto the bus, each stamped with a destination ID.
- Raises done when the last beat is issued.

Parameters:
- DATA_WIDTH, 16, ifmap/filter width; psum is 2*DATA_WIDTH.
- NUM_COL, 8, number of column multicasters on the bus.
- LEN_W, 16, width of the beat counter.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  tag-table write strobe
- cfg_addr  in  $clog2(NUM_COL)  column index to write
- cfg_tag  in  $clog2(NUM_COL)+1  TAG value for that column
- cfg_kernel_size  in  8  kernel size for the job
- cfg_len  in  LEN_W  number of stream beats
- start  in  1  job start pulse
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at job end
- src_valid  in  1  source beat valid
- src_ready  out  1  source beat accepted
- src_id  in  $clog2(NUM_COL)+1  destination ID of the beat
- src_ifmap  in  DATA_WIDTH  source ifmap data
- src_fltr  in  DATA_WIDTH  source filter data
- src_psum  in  2*DATA_WIDTH  source partial-sum data
- ID  out  $clog2(NUM_COL)+1  bus ID (target column in config phase, src_id in stream phase)
- TAG  out  $clog2(NUM_COL)+1  tag value for flush_tag
- flush_tag  out  1  tag load pulse
- tag_busy  in  1  multicaster still loading tag
- flush_kernel  out  1  kernel-size load pulse
- kernel_busy  in  1  multicasters still loading kernel size
- kernel_size  out  8  latched kernel size
- bus_valid  out  1  bus data valid
- ifmap_data_B2M  out  DATA_WIDTH  ifmap data to multicasters
- fltr_data_B2M  out  DATA_WIDTH  filter data to multicasters
- psum_data_B2M  out  2*DATA_WIDTH  psum data to multicasters

Behaviour:
- Reset values (asynchronous on rst_n low): all outputs 0, except ID = TAG = all-ones (NO_ID, matches no column). State IDLE. Tag table cleared to NO_ID.
- All bus outputs are registered. Bus data appears 1 cycle after the src handshake.
- Tag table: NUM_COL entries. Written on cfg_we only in IDLE; cfg_we is ignored while busy.
- IDLE:
  - start=1: latch cfg_kernel_size into kernel_size and cfg_len into len_r; set busy=1; go KFLUSH.
  - start while busy is ignored.
- KFLUSH: flush_kernel=1 for exactly 1 cycle, then go KWAIT.
- KWAIT:
  - Stays at least 1 cycle, since multicasters assert busy the cycle after the flush.
  - Leaves when kernel_busy=0 is sampled, with col=0, to TFLUSH.
- TFLUSH: ID=col, TAG=table[col], flush_tag=1 for 1 cycle, then go TWAIT.
- TWAIT:
  - Minimum 1 cycle; waits for tag_busy=0.
  - If col==NUM_COL-1: go STREAM with cnt=0, or DONE when len_r==0. Otherwise col++ and go TFLUSH.
  - ID/TAG hold their values throughout TWAIT.
- STREAM:
  - src_ready=1, combinational on state only. Each src_valid&&src_ready beat registers onto the bus: bus_valid=1, ID=src_id, data words copied; cnt++.
  - A cycle with no beat gives bus_valid=0 and ID=NO_ID.
  - When the beat making cnt==len_r is accepted, go DONE. src_ready=0 from the next cycle.
- DONE: done=1 for 1 cycle, busy=0 in the same cycle, ID=NO_ID, bus_valid=0; go IDLE.
- start is accepted again from the cycle after DONE.
- The bus has no backpressure; the source carries all flow control.
- flush_tag and flush_kernel are never high together. They are never high while bus_valid is high.
- Reset mid-job returns to IDLE immediately. No done pulse is produced, and the tag table is cleared.
- Counter wrap is not possible, since cnt is bounded by len_r (LEN_W bits).

Decomposition:
- Package bus_seq_pkg holds:
  - state enum {IDLE, KFLUSH, KWAIT, TFLUSH, TWAIT, STREAM, DONE};
  - localparam ID_W = $clog2(NUM_COL)+1;
  - NO_ID = '1.
- Sub-module tag_table: NUM_COL x ID_W register file with 1 write port and 1 combinational read port, plus reset clear.
- The FSM, counters and output registers stay in the top module.

Test Plan:
- Write tags {3,2,1,0,...} to cols 0..7, start with kernel_size=3 and len=4; kernel_busy and tag_busy each high for 2 cycles after their flush.
  - Expect 1 flush_kernel pulse, kernel_size=3, then 8 flush_tag pulses with ID=0..7 / TAG=table, each spaced by the busy time.
  - Then 4 bus_valid beats carrying src data 1 cycle late, then done with busy falling.
- len=0: after the 8th tag flush go straight to done. src_ready never asserted.
- src_valid toggling 1,0,1,1 in STREAM with len=3.
  - bus_valid follows 1 cycle later, with ID=NO_ID on the gap.
  - Exactly 3 beats; src_ready drops after the 3rd.
- start and cfg_we asserted during STREAM: no restart; the table is unchanged (read back via a second job).
- kernel_busy held high for 50 cycles: FSM stays in KWAIT, and flush_tag/bus_valid stay 0 throughout.
- rst_n pulsed low in TWAIT at col=4:
  - All outputs reset asynchronously, ID=NO_ID, no done.
  - A new start replays from KFLUSH with the table set to NO_ID.
